ldq_ret_ctrl: RTL and testbench
===============================

# ldq_ret_ctrl

Load-buffer ID retirement controller for the dispatch stage; the return side of the dispatch load-ID allocator. It tracks every load-buffer ID the allocator hands out, records ROB commit of each load, and frees IDs strictly in allocation order, up to 4 per cycle. Its `o_ret_vld` drives the allocator's `i_dsp_ldq_ret_vld`, so the allocator's read pointer and this block's head pointer always advance together.

## Interface
- `LBUFF_DEPTH`, 32, number of load-buffer IDs; power of two.
- `ID_WIDTH`, 5, equals `` `LBUFF_ID_WIDTH ``, log2(`LBUFF_DEPTH`).
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `i_csr_trap_flush` in 1: full flush.
- `i_exu_ls_flush`, `i_exu_mis_flush` in 1 each: partial-flush sources.
- `i_rob_mis_ld_vld` in 1: qualifies a partial flush.
- `i_rob_mis_ld_id` in `ID_WIDTH`: oldest flushed ID.
- `i_alloc_fire` in 4: allocations granted this cycle (allocator request vld, already gated by stall and full); IDs are consecutive from the tail.
- `i_cmt_vld` in 4: ROB load-commit valids.
- `i_cmt_id_0..3` in `ID_WIDTH` each: IDs of committed loads.
- `o_ret_vld` out 4: thermometer of IDs freed this cycle (bit0 first).
- `o_ret_id` out `ID_WIDTH`: oldest freed ID (head).
- `o_ldq_cnt` out `ID_WIDTH+1`: occupied IDs.
- `o_ldq_err` out 1: sticky protocol-error flag.

## Operation
- State: per-ID `alloc` and `cmt` bits; head `h`, tail `t` (`ID_WIDTH`, modulo `LBUFF_DEPTH`); count `c` (`ID_WIDTH+1`, 0..32).
- Allocate: `n` = popcount(`i_alloc_fire`). Set `alloc` and clear `cmt` at `t`..`t+n-1` modulo depth; `t += n`.
  - If `c + n - k > LBUFF_DEPTH`, the allocation is dropped and `o_ldq_err` is set.
- Commit: for each valid lane, set `cmt[id]`.
  - A commit to an ID with `alloc=0` is ignored and sets `o_ldq_err`.
  - Duplicate IDs across lanes are legal.
- Retire: `k` = number of consecutive entries starting at `h` with registered `cmt=1`, capped at 4 and at `c`.
  - `o_ret_vld` = thermometer(`k`); `o_ret_id` = `h`.
  - On the clock edge, clear `alloc`/`cmt` of the retired IDs and set `h += k`.
- Count: `c_next = c + n - k`.
- Partial flush, `pf = (i_exu_ls_flush | i_exu_mis_flush) & i_rob_mis_ld_vld`:
  - Clear `alloc`/`cmt` for IDs from `i_rob_mis_ld_id` up to old `t`, and set `t = i_rob_mis_ld_id`.
  - Allocation is ignored that cycle. Retirement proceeds that cycle.
  - `c_next = ((i_rob_mis_ld_id - h) mod LBUFF_DEPTH) - k`. `i_rob_mis_ld_id == h` flushes all uncommitted entries, giving `c = 0`.
- Trap flush has top priority:
  - All bits clear; `h = t = 0`; `c = 0`.
  - `o_ret_vld = 0` that cycle; allocation, commit and `pf` are ignored.
- `o_ldq_err` clears only on `rst`.

## Timing
- Reset values: `o_ret_vld = 0`, `o_ret_id = 0`, `o_ldq_cnt = 0`, `o_ldq_err = 0`; all `alloc`/`cmt` bits 0; `h = t = 0`.
- `o_ret_vld`/`o_ret_id` are combinational from registered state (default build).
- A commit in cycle N retires no earlier than N+1. An allocation in cycle N is committable from N+1.
- `o_ldq_cnt` is registered and reflects the previous edge.
- `rst` asserted mid-operation discards all state at the next edge, regardless of flush inputs.
- Wrap-around: retiring or allocating across ID 31→0 is seamless; a full queue with `c = 32` and `h == t` is legal.

## Configuration
- `LDQ_RET_OUT_REG_EN`:
  - Defined: `o_ret_vld` and `o_ret_id` pass through an output register, one cycle of added latency. Internal state still updates in the retire cycle. A trap flush or `rst` zeroes the register at the same edge.
  - Undefined: outputs are combinational as above.

## Test plan
- Reset; `i_alloc_fire = 1111`; next cycle commit IDs 0..3 → following cycle `o_ret_vld = 1111`, `o_ret_id = 0`; `o_ldq_cnt` goes 4 → 0.
- Allocate 3; commit ID 2, then 1, then 0 on successive cycles → `o_ret_vld = 0000` until the cycle after ID 0 commits, then `0111`.
- Advance `h` to 30; allocate 4 (IDs 30, 31, 0, 1); commit all → `o_ret_vld = 1111`, `o_ret_id = 30`, next `o_ret_id = 2`.
- Allocate 8 (IDs 0..7); commit 0, 1; next cycle `pf` with `i_rob_mis_ld_id = 4` → `o_ret_vld = 0011` that cycle, `o_ldq_cnt = 2`; the next allocation takes ID 4.
- `o_ldq_cnt = 5` with committed head, then `i_csr_trap_flush` → `o_ret_vld = 0000` that cycle, `o_ldq_cnt = 0`, the next allocation takes ID 0.
- Commit ID 9 while unallocated → `o_ldq_err = 1`, stays high; with `o_ldq_cnt = 30`, `i_alloc_fire = 1111` → dropped, `o_ldq_cnt` stays 30.

Source files
------------

// File: rtl/ldq_ret_ctrl_if.sv
// Handshake bundle between the dispatch/ROB side and the load-ID retirement
// controller. master drives requests and flushes; slave is the controller.
interface ldq_ret_ctrl_if #(
  parameter int ID_WIDTH = 5
);
  logic                i_csr_trap_flush;
  logic                i_exu_ls_flush;
  logic                i_exu_mis_flush;
  logic                i_rob_mis_ld_vld;
  logic [ID_WIDTH-1:0] i_rob_mis_ld_id;
  logic [3:0]          i_alloc_fire;
  logic [3:0]          i_cmt_vld;
  logic [ID_WIDTH-1:0] i_cmt_id_0;
  logic [ID_WIDTH-1:0] i_cmt_id_1;
  logic [ID_WIDTH-1:0] i_cmt_id_2;
  logic [ID_WIDTH-1:0] i_cmt_id_3;
  logic [3:0]          o_ret_vld;
  logic [ID_WIDTH-1:0] o_ret_id;
  logic [ID_WIDTH:0]   o_ldq_cnt;
  logic                o_ldq_err;

  modport master (
    output i_csr_trap_flush, i_exu_ls_flush, i_exu_mis_flush,
    output i_rob_mis_ld_vld, i_rob_mis_ld_id, i_alloc_fire, i_cmt_vld,
    output i_cmt_id_0, i_cmt_id_1, i_cmt_id_2, i_cmt_id_3,
    input  o_ret_vld, o_ret_id, o_ldq_cnt, o_ldq_err
  );

  modport slave (
    input  i_csr_trap_flush, i_exu_ls_flush, i_exu_mis_flush,
    input  i_rob_mis_ld_vld, i_rob_mis_ld_id, i_alloc_fire, i_cmt_vld,
    input  i_cmt_id_0, i_cmt_id_1, i_cmt_id_2, i_cmt_id_3,
    output o_ret_vld, o_ret_id, o_ldq_cnt, o_ldq_err
  );
endinterface

// File: rtl/ldq_ret_ctrl.sv
// Load-buffer ID retirement controller. Tracks allocated/committed load IDs
// and frees them in allocation order, up to four per cycle.
// Optional macro LDQ_RET_OUT_REG_EN adds an output register on o_ret_vld /
// o_ret_id (one cycle of extra latency); undefined gives combinational outputs.
module ldq_ret_ctrl #(
  parameter int LBUFF_DEPTH = 32,
  parameter int ID_WIDTH    = 5
) (
  input  logic        clk,
  input  logic        rst,
  ldq_ret_ctrl_if.slave bus
);
  typedef logic [ID_WIDTH-1:0] id_t;
  typedef logic [ID_WIDTH:0]   cnt_t;

  logic [LBUFF_DEPTH-1:0] alloc_reg, alloc_next;
  logic [LBUFF_DEPTH-1:0] cmt_reg, cmt_next;
  id_t                    head_reg, head_next;
  id_t                    tail_reg, tail_next;
  cnt_t                   cnt_reg, cnt_next;
  logic                   err_reg, err_next;

  logic                   trap;
  logic                   pf;
  logic [3:0]             hit;
  logic [3:0]             therm;
  logic [2:0]             k;
  logic [2:0]             n;
  logic [ID_WIDTH+1:0]    alloc_sum;
  logic                   alloc_over;
  id_t                    mis_off;
  cnt_t                   pf_eff;
  logic [LBUFF_DEPTH-1:0] flush_mask;
  logic [3:0]             ret_vld_comb;
  id_t                    cmt_id [4];

  assign cmt_id[0] = bus.i_cmt_id_0;
  assign cmt_id[1] = bus.i_cmt_id_1;
  assign cmt_id[2] = bus.i_cmt_id_2;
  assign cmt_id[3] = bus.i_cmt_id_3;

  assign trap = bus.i_csr_trap_flush;
  assign pf   = (bus.i_exu_ls_flush | bus.i_exu_mis_flush) & bus.i_rob_mis_ld_vld;

  genvar gi;

  // A head-relative slot is retirable when committed and actually occupied.
  for (gi = 0; gi < 4; gi++) begin : g_hit
    assign hit[gi] = cmt_reg[head_reg + id_t'(gi)] & (cnt_reg > cnt_t'(gi));
  end

  // Retirement stops at the first uncommitted slot, so only a prefix counts.
  assign therm[0] = hit[0];
  for (gi = 1; gi < 4; gi++) begin : g_therm
    assign therm[gi] = therm[gi-1] & hit[gi];
  end

  assign k = 3'(therm[0]) + 3'(therm[1]) + 3'(therm[2]) + 3'(therm[3]);
  assign n = 3'(bus.i_alloc_fire[0]) + 3'(bus.i_alloc_fire[1]) +
             3'(bus.i_alloc_fire[2]) + 3'(bus.i_alloc_fire[3]);

  assign alloc_sum  = (ID_WIDTH+2)'(cnt_reg) + (ID_WIDTH+2)'(n) - (ID_WIDTH+2)'(k);
  assign alloc_over = alloc_sum > (ID_WIDTH+2)'(LBUFF_DEPTH);

  assign mis_off = bus.i_rob_mis_ld_id - head_reg;

  // Flush point as an occupancy offset; clamped so already-retiring entries
  // survive and a point beyond the tail flushes nothing.
  always_comb begin
    pf_eff = {1'b0, mis_off};
    if (pf_eff < cnt_t'(k)) begin
      pf_eff = cnt_t'(k);
    end
    if (pf_eff > cnt_reg) begin
      pf_eff = cnt_reg;
    end
  end

  // Every ID at or beyond the flush offset (relative to head) is squashed.
  for (gi = 0; gi < LBUFF_DEPTH; gi++) begin : g_flush
    id_t off;
    assign off            = id_t'(gi) - head_reg;
    assign flush_mask[gi] = ({1'b0, off} >= pf_eff);
  end

  assign ret_vld_comb = trap ? 4'b0000 : therm;

  // Next-state: commit, retire, allocate, partial flush, then trap override.
  always_comb begin
    alloc_next = alloc_reg;
    cmt_next   = cmt_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;

    // Commits only land on allocated IDs; anything else is a protocol error.
    for (int l = 0; l < 4; l++) begin
      if (bus.i_cmt_vld[l]) begin
        if (alloc_reg[cmt_id[l]]) begin
          cmt_next[cmt_id[l]] = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
    end

    // Retire clears before allocate so a full queue can reuse freed slots.
    for (int j = 0; j < 4; j++) begin
      if (therm[j]) begin
        alloc_next[head_reg + id_t'(j)] = 1'b0;
        cmt_next[head_reg + id_t'(j)]   = 1'b0;
      end
    end
    head_next = head_reg + id_t'(k);
    cnt_next  = cnt_reg - cnt_t'(k);

    if (pf) begin
      alloc_next = alloc_next & ~flush_mask;
      cmt_next   = cmt_next & ~flush_mask;
      tail_next  = head_reg + pf_eff[ID_WIDTH-1:0];
      cnt_next   = pf_eff - cnt_t'(k);
    end else if (n != 3'd0) begin
      if (alloc_over) begin
        err_next = 1'b1;
      end else begin
        for (int j = 0; j < 4; j++) begin
          if (3'(j) < n) begin
            alloc_next[tail_reg + id_t'(j)] = 1'b1;
            cmt_next[tail_reg + id_t'(j)]   = 1'b0;
          end
        end
        tail_next = tail_reg + id_t'(n);
        cnt_next  = alloc_sum[ID_WIDTH:0];
      end
    end

    if (trap) begin
      alloc_next = '0;
      cmt_next   = '0;
      head_next  = '0;
      tail_next  = '0;
      cnt_next   = '0;
      err_next   = err_reg;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_reg <= '0;
      cmt_reg   <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      alloc_reg <= alloc_next;
      cmt_reg   <= cmt_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign bus.o_ldq_cnt = cnt_reg;
  assign bus.o_ldq_err = err_reg;

`ifdef LDQ_RET_OUT_REG_EN
  logic [3:0] ret_vld_reg;
  id_t        ret_id_reg;

  // Delayed copy of the retire outputs; trap and reset zero it immediately.
  always_ff @(posedge clk) begin
    if (rst || trap) begin
      ret_vld_reg <= 4'b0000;
      ret_id_reg  <= '0;
    end else begin
      ret_vld_reg <= ret_vld_comb;
      ret_id_reg  <= head_reg;
    end
  end

  assign bus.o_ret_vld = ret_vld_reg;
  assign bus.o_ret_id  = ret_id_reg;
`else
  assign bus.o_ret_vld = ret_vld_comb;
  assign bus.o_ret_id  = head_reg;
`endif
endmodule

// File: tb/tb_ldq_ret_ctrl.sv
// Scoreboard bench for ldq_ret_ctrl: stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever o_ret_vld is non-zero.
module tb_ldq_ret_ctrl;
  localparam int W = 5;
`ifdef LDQ_RET_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldq_ret_ctrl_if #(.ID_WIDTH(W)) bus();

  ldq_ret_ctrl #(.LBUFF_DEPTH(32), .ID_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] vld;
    logic [4:0] id;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   tb_h  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented retirement must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_ret_vld != 4'b0000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_ret: cyc=%0d got vld=%b id=%0d, required none",
                 cyc, bus.o_ret_vld, bus.o_ret_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.vld != bus.o_ret_vld || e.id != bus.o_ret_id) begin
          n_mis++;
          $display("FAIL ret: got cyc=%0d vld=%b id=%0d, required cyc=%0d vld=%b id=%0d",
                   cyc, bus.o_ret_vld, bus.o_ret_id, e.cyc, e.vld, e.id);
        end else begin
          $display("ret  cyc=%0d vld=%b id=%0d ok", cyc, bus.o_ret_vld, bus.o_ret_id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] therm(input int c);
    case (c)
      1:       return 4'b0001;
      2:       return 4'b0011;
      3:       return 4'b0111;
      4:       return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic idle();
    bus.i_csr_trap_flush = 1'b0;
    bus.i_exu_ls_flush   = 1'b0;
    bus.i_exu_mis_flush  = 1'b0;
    bus.i_rob_mis_ld_vld = 1'b0;
    bus.i_rob_mis_ld_id  = '0;
    bus.i_alloc_fire     = 4'b0000;
    bus.i_cmt_vld        = 4'b0000;
    bus.i_cmt_id_0       = '0;
    bus.i_cmt_id_1       = '0;
    bus.i_cmt_id_2       = '0;
    bus.i_cmt_id_3       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input int l, input int id);
    bus.i_cmt_vld[l] = 1'b1;
    case (l)
      0:       bus.i_cmt_id_0 = 5'(id);
      1:       bus.i_cmt_id_1 = 5'(id);
      2:       bus.i_cmt_id_2 = 5'(id);
      default: bus.i_cmt_id_3 = 5'(id);
    endcase
  endtask

  task automatic expect_ret(input logic [3:0] v, input int id);
    exp_t e;
    e.cyc = cyc + LAT;
    e.vld = v;
    e.id  = 5'(id);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic status(input string name, input int c, input int e);
    @(negedge clk);
    chk({name, "_cnt"}, int'(bus.o_ldq_cnt), c);
    chk({name, "_err"}, int'(bus.o_ldq_err), e);
  endtask

  // Allocate n IDs from an empty queue, commit them all, expect one retire.
  task automatic round(input int n);
    idle();
    bus.i_alloc_fire = therm(n);
    tick();
    idle();
    for (int j = 0; j < n; j++) commit(j, (tb_h + j) % 32);
    status("round_alloc", n, 0);
    tick();
    idle();
    expect_ret(therm(n), tb_h);
    status("round_ret", n, 0);
    tick();
    tb_h = (tb_h + n) % 32;
  endtask

  initial begin
    idle();
    repeat (3) tick();
    rst = 1'b0;
    status("reset", 0, 0);
    chk("reset_ret_id", int'(bus.o_ret_id), 0);
    chk("reset_ret_vld", int'(bus.o_ret_vld), 0);
    tick();

    // Four allocations committed together retire together.
    round(4);
    status("t1_drain", 0, 0);

    // Out-of-order commits hold retirement until the head commits.
    idle(); bus.i_alloc_fire = 4'b0111; tick();
    idle(); commit(0, 6); status("t2_a", 3, 0); tick();
    idle(); commit(0, 5); tick();
    idle(); commit(0, 4); tick();
    idle(); expect_ret(4'b0111, 4); tick();
    tb_h = 7;
    status("t2_drain", 0, 0);

    // Walk head to 30, then retire across the 31 -> 0 wrap.
    repeat (5) round(4);
    round(3);
    round(4);
    idle(); tick();
    @(negedge clk);
    chk("wrap_next_ret_id", int'(bus.o_ret_id), 2);

    // Partial flush at head+4 while two head entries retire.
    idle(); bus.i_alloc_fire = 4'b1111; tick();
    idle(); bus.i_alloc_fire = 4'b1111; status("pf_a", 4, 0); tick();
    idle(); commit(0, 2); commit(1, 3); status("pf_b", 8, 0); tick();
    idle();
    bus.i_exu_mis_flush  = 1'b1;
    bus.i_rob_mis_ld_vld = 1'b1;
    bus.i_rob_mis_ld_id  = 5'd6;
    bus.i_alloc_fire     = 4'b1111;
    expect_ret(4'b0011, 2);
    status("pf_c", 8, 0);
    tick();
    idle(); bus.i_alloc_fire = 4'b0001; status("pf_after", 2, 0); tick();
    idle(); commit(0, 4); commit(1, 5); commit(2, 6); status("pf_realloc", 3, 0); tick();
    idle(); expect_ret(4'b0111, 4); tick();
    tb_h = 7;
    status("pf_drain", 0, 0);

    // Trap flush with a committed head suppresses retirement.
    idle(); bus.i_alloc_fire = 4'b1111; tick();
    idle(); bus.i_alloc_fire = 4'b0001; commit(0, 7); commit(1, 8); tick();
    idle();
    bus.i_csr_trap_flush = 1'b1;
    bus.i_alloc_fire     = 4'b1111;
    bus.i_exu_ls_flush   = 1'b1;
    bus.i_rob_mis_ld_vld = 1'b1;
    bus.i_rob_mis_ld_id  = 5'd9;
    commit(0, 20);
    status("trap_cyc", 5, 0);
    chk("trap_ret_vld", int'(bus.o_ret_vld), 0);
    tick();
    idle(); bus.i_alloc_fire = 4'b0001;
    status("trap_after", 0, 0);
    chk("trap_ret_id", int'(bus.o_ret_id), 0);
    tick();
    idle(); commit(0, 0); status("trap_realloc", 1, 0); tick();
    idle(); expect_ret(4'b0001, 0); tick();
    tb_h = 1;

    // Commit to an unallocated ID raises the sticky error.
    idle(); commit(0, 9); tick();
    idle(); status("err_set", 0, 1); tick();
    status("err_sticky", 0, 1);
    for (int r = 0; r < 7; r++) begin
      idle(); bus.i_alloc_fire = 4'b1111; tick();
    end
    idle(); bus.i_alloc_fire = 4'b0011; tick();
    idle(); status("fill30", 30, 1);
    bus.i_alloc_fire = 4'b1111; tick();
    idle(); status("drop30", 30, 1); tick();

    // Reset mid-operation wins over a concurrent flush request.
    idle();
    rst = 1'b1;
    bus.i_exu_mis_flush  = 1'b1;
    bus.i_rob_mis_ld_vld = 1'b1;
    bus.i_rob_mis_ld_id  = 5'd3;
    tick();
    rst = 1'b0;
    idle();
    status("rst_mid", 0, 0);
    chk("rst_mid_ret_id", int'(bus.o_ret_id), 0);

    // Fill to exactly 32 (h == t is legal), then overflow by one.
    for (int r = 0; r < 8; r++) begin
      idle(); bus.i_alloc_fire = 4'b1111; tick();
    end
    idle(); status("full32", 32, 0);
    bus.i_alloc_fire = 4'b0001; tick();
    idle(); status("over32", 32, 1);
    repeat (3) tick();

    chk("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
